// File: rtl/lbm_step_sequencer_pkg.sv
// Shared definitions for the LBM step sequencer: phase and FSM state
// encodings, default geometry, and small state-decode helpers.
package lbm_step_sequencer_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_NUM_WORDS = 2500;
    localparam int DEF_PIPE_LAT  = 4;
    localparam int DEF_STEP_W    = 32;

    typedef enum logic [1:0] {
        PHASE_IDLE    = 2'd0,
        PHASE_COLLIDE = 2'd1,
        PHASE_STREAM  = 2'd2
    } phase_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_C_ISSUE = 3'd1,
        ST_C_DRAIN = 3'd2,
        ST_S_ISSUE = 3'd3,
        ST_S_DRAIN = 3'd4,
        ST_SWAP    = 3'd5,
        ST_FIN     = 3'd6
    } seq_state_e;

    // Phase reported to the RAM muxing; the swap cycle still belongs to STREAM.
    function automatic phase_e state_phase(input seq_state_e st);
        phase_e ph;
        case (st)
            ST_C_ISSUE, ST_C_DRAIN:         ph = PHASE_COLLIDE;
            ST_S_ISSUE, ST_S_DRAIN, ST_SWAP: ph = PHASE_STREAM;
            default:                        ph = PHASE_IDLE;
        endcase
        return ph;
    endfunction

    // A run is in progress in every state except IDLE and the FIN pulse.
    function automatic logic state_busy(input seq_state_e st);
        logic b;
        case (st)
            ST_IDLE, ST_FIN: b = 1'b0;
            default:         b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lbm_step_sequencer_if.sv
// Host/core-facing bundle of the step sequencer. The master modport is the
// sequencer itself; the slave modport is whatever drives start/abort and the
// core readiness and consumes the addresses and status.
interface lbm_step_sequencer_if
    import lbm_step_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int STEP_W = DEF_STEP_W
) ();

    logic              start;
    logic              abort;
    logic [STEP_W-1:0] step_target;
    logic              core_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [1:0]        phase;
    logic              bank_sel;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_done;

    modport master (
        input  start, abort, step_target, core_ready,
        output rd_addr, rd_valid, wr_addr, wr_en, phase, bank_sel, busy, done, steps_done
    );

    modport slave (
        output start, abort, step_target, core_ready,
        input  rd_addr, rd_valid, wr_addr, wr_en, phase, bank_sel, busy, done, steps_done
    );

endinterface

// File: rtl/lbm_seq_delay_line.sv
// Fixed-latency shift line for {valid, data}. Advances every cycle, so a
// bubble on the input reappears as an invalid slot DEPTH cycles later.
// flush drops every in-flight entry on the next edge.
module lbm_seq_delay_line #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             tail_valid,
    output logic [WIDTH-1:0] tail_data,
    output logic             pending
);

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];

    // Shift register stages; reset and flush clear both valid and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign tail_valid = valid_r[DEPTH-1];
    assign tail_data  = data_r[DEPTH-1];
    assign pending    = |valid_r;

endmodule

// File: rtl/lbm_step_sequencer.sv
// Whole-timestep sequencer for the 18-RAM LBM datapath. Each step is a
// COLLIDE sweep, a STREAM sweep and a ping-pong bank swap. One read address
// is issued per accepted cycle; the matching write address/strobe comes out
// of a fixed-latency delay line. The FSM waits for that line to empty before
// changing phase so no write of one phase lands in the next.
module lbm_step_sequencer
    import lbm_step_sequencer_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int PIPE_LAT  = DEF_PIPE_LAT,
    parameter int STEP_W    = DEF_STEP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    lbm_step_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 32'd1);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    seq_state_e        state_r;
    seq_state_e        state_step_s;
    seq_state_e        state_nx_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_nx_s;
    logic [STEP_W-1:0] target_r;
    logic [STEP_W-1:0] steps_done_r;
    logic              bank_sel_r;
    logic              busy_r;
    logic              done_r;
    phase_e            phase_r;

    logic              issue_s;
    logic              last_s;
    logic              abort_s;
    logic              start_acc_s;
    logic              swap_s;
    logic              dl_pending_s;
    logic              dl_valid_s;
    logic [ADDR_W-1:0] dl_addr_s;

    // A read goes out only in an issue state and only when the core takes it.
    assign issue_s     = ((state_r == ST_C_ISSUE) || (state_r == ST_S_ISSUE)) && bus.core_ready;
    assign last_s      = (idx_r == LAST_IDX);
    // abort only matters while a run is in progress; in IDLE it also masks start.
    assign abort_s     = bus.abort && state_busy(state_r);
    assign start_acc_s = (state_r == ST_IDLE) && bus.start && !bus.abort;
    assign swap_s      = (state_r == ST_S_DRAIN) && (state_nx_s == ST_SWAP);

    // Next-state and word-index logic; abort overrides every transition.
    always_comb begin
        state_step_s = state_r;
        idx_nx_s     = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_step_s = (bus.step_target == STEP_ZERO) ? ST_FIN : ST_C_ISSUE;
                end else begin
                    state_step_s = ST_IDLE;
                end
            end
            ST_C_ISSUE: begin
                if (issue_s && last_s) begin
                    state_step_s = ST_C_DRAIN;
                end else begin
                    state_step_s = ST_C_ISSUE;
                end
            end
            ST_C_DRAIN: begin
                if (!dl_pending_s) begin
                    state_step_s = ST_S_ISSUE;
                end else begin
                    state_step_s = ST_C_DRAIN;
                end
            end
            ST_S_ISSUE: begin
                if (issue_s && last_s) begin
                    state_step_s = ST_S_DRAIN;
                end else begin
                    state_step_s = ST_S_ISSUE;
                end
            end
            ST_S_DRAIN: begin
                if (!dl_pending_s) begin
                    state_step_s = ST_SWAP;
                end else begin
                    state_step_s = ST_S_DRAIN;
                end
            end
            ST_SWAP: begin
                if (steps_done_r == target_r) begin
                    state_step_s = ST_FIN;
                end else begin
                    state_step_s = ST_C_ISSUE;
                end
            end
            ST_FIN:  state_step_s = ST_IDLE;
            default: state_step_s = ST_IDLE;
        endcase

        if (abort_s) begin
            state_nx_s = ST_IDLE;
            idx_nx_s   = IDX_ZERO;
        end else if (issue_s) begin
            state_nx_s = state_step_s;
            idx_nx_s   = last_s ? IDX_ZERO : (idx_r + IDX_ONE);
        end else begin
            state_nx_s = state_step_s;
            idx_nx_s   = idx_r;
        end
    end

    // FSM state and word index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Run bookkeeping and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_r     <= STEP_ZERO;
            steps_done_r <= STEP_ZERO;
            bank_sel_r   <= 1'b0;
            phase_r      <= PHASE_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (start_acc_s) begin
                target_r     <= bus.step_target;
                steps_done_r <= STEP_ZERO;
            end else if (swap_s) begin
                steps_done_r <= steps_done_r + STEP_ONE;
            end else begin
                steps_done_r <= steps_done_r;
            end
            if (swap_s) begin
                bank_sel_r <= ~bank_sel_r;
            end else begin
                bank_sel_r <= bank_sel_r;
            end
            phase_r <= state_phase(state_nx_s);
            busy_r  <= state_busy(state_nx_s);
            done_r  <= (state_nx_s == ST_FIN);
        end
    end

    lbm_seq_delay_line #(
        .WIDTH (ADDR_W),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort_s),
        .in_valid   (issue_s),
        .in_data    (idx_r),
        .tail_valid (dl_valid_s),
        .tail_data  (dl_addr_s),
        .pending    (dl_pending_s)
    );

    assign bus.rd_addr    = idx_r;
    assign bus.rd_valid   = issue_s;
    assign bus.wr_addr    = dl_addr_s;
    assign bus.wr_en      = dl_valid_s;
    assign bus.phase      = phase_r;
    assign bus.bank_sel   = bank_sel_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.steps_done = steps_done_r;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Scoreboard bench for lbm_step_sequencer. The reference model expands a run
// of T steps into the expected read/write streams (phase, address, bank) and
// the expected completion record; a separate monitor pops and compares
// whenever the DUT presents a read, a write or a done pulse.
module tb_lbm_step_sequencer;
    import lbm_step_sequencer_pkg::*;

    localparam int ADDR_W    = 12;
    localparam int NUM_WORDS = 8;
    localparam int PIPE_LAT  = 4;
    localparam int STEP_W    = 32;

    typedef struct { int ph; int addr; int bank; } ev_t;
    typedef struct { int steps; int bank; } dn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   bank_m = 0;
    bit   rand_ready = 1'b0;
    logic ready_val = 1'b1;

    ev_t exp_rd[$];
    ev_t exp_wr[$];
    dn_t exp_dn[$];
    int  lat_q[$];

    lbm_step_sequencer_if #(.ADDR_W(ADDR_W), .STEP_W(STEP_W)) bus ();

    lbm_step_sequencer #(
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM_WORDS),
        .PIPE_LAT  (PIPE_LAT),
        .STEP_W    (STEP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a run of t steps is t x (COLLIDE 0..N-1, STREAM 0..N-1),
    // bank flipping after each completed step.
    task automatic plan_run(input int t);
        ev_t e;
        dn_t d;
        for (int s = 0; s < t; s++) begin
            for (int p = 1; p <= 2; p++) begin
                for (int a = 0; a < NUM_WORDS; a++) begin
                    e.ph = p; e.addr = a; e.bank = bank_m;
                    exp_rd.push_back(e);
                    exp_wr.push_back(e);
                end
            end
            bank_m = bank_m ^ 1;
        end
        d.steps = t; d.bank = bank_m;
        exp_dn.push_back(d);
    endtask

    task automatic clear_model();
        exp_rd.delete(); exp_wr.delete(); exp_dn.delete(); lat_q.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
        if (rand_ready) bus.core_ready = ($urandom_range(0, 3) != 0);
        else            bus.core_ready = ready_val;
    endtask

    task automatic launch(input int t);
        plan_run(t);
        tick();
        bus.start = 1'b1;
        bus.step_target = STEP_W'(t);
        tick();
        bus.start = 1'b0;
        chk("steps_cleared_on_start", int'(bus.steps_done), 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int last = int'(bus.steps_done);
        while (n < budget && bus.done !== 1'b1) begin
            tick();
            n++;
            if (int'(bus.steps_done) != last) begin
                chk("steps_increment", int'(bus.steps_done), last + 1);
                last = int'(bus.steps_done);
            end
        end
        chk("done_within_budget", int'(n < budget), 1);
        tick();
        chk("done_single_cycle", int'(bus.done), 0);
        chk("idle_after_done", int'(bus.busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({tag, "_rd_valid"}, int'(bus.rd_valid), 0);
        chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
        chk({tag, "_phase"}, int'(bus.phase), 0);
        chk({tag, "_bank_sel"}, int'(bus.bank_sel), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_steps_done"}, int'(bus.steps_done), 0);
    endtask

    // Monitor: compares every read, write and done pulse against the model.
    initial begin : monitor
        ev_t e;
        dn_t d;
        int  lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.rd_valid) begin
                    chk("rd_only_when_ready", int'(bus.core_ready), 1);
                    chk("rd_expected", int'(exp_rd.size() != 0), 1);
                    if (exp_rd.size() != 0) begin
                        e = exp_rd.pop_front();
                        chk("rd_addr", int'(bus.rd_addr), e.addr);
                        chk("rd_phase", int'(bus.phase), e.ph);
                        chk("rd_bank", int'(bus.bank_sel), e.bank);
                        lat_q.push_back(cyc + PIPE_LAT);
                    end
                end
                if (bus.wr_en) begin
                    chk("wr_expected", int'(exp_wr.size() != 0), 1);
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", int'(bus.wr_addr), e.addr);
                        chk("wr_phase", int'(bus.phase), e.ph);
                        chk("wr_bank", int'(bus.bank_sel), e.bank);
                    end
                    chk("wr_has_read", int'(lat_q.size() != 0), 1);
                    if (lat_q.size() != 0) begin
                        lat = lat_q.pop_front();
                        chk("wr_latency", cyc, lat);
                    end
                end
                if (bus.done) begin
                    chk("done_expected", int'(exp_dn.size() != 0), 1);
                    if (exp_dn.size() != 0) begin
                        d = exp_dn.pop_front();
                        chk("done_steps", int'(bus.steps_done), d.steps);
                        chk("done_bank", int'(bus.bank_sel), d.bank);
                        chk("done_busy_low", int'(bus.busy), 0);
                        chk("done_reads_left", int'(exp_rd.size()), 0);
                        chk("done_writes_left", int'(exp_wr.size()), 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int run_bank;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.step_target = '0;
        bus.core_ready = 1'b0;
        #2;
        check_reset_outputs("por");
        #10 rst = 1'b1;

        // One step, core always ready.
        ready_val = 1'b1;
        launch(1);
        wait_done(200);

        // Three steps, core always ready.
        launch(3);
        wait_done(400);

        // Zero steps: done the cycle after start, nothing issued.
        run_bank = bank_m;
        plan_run(0);
        tick();
        bus.start = 1'b1;
        bus.step_target = '0;
        tick();
        bus.start = 1'b0;
        chk("t0_done_next_cycle", int'(bus.done), 1);
        chk("t0_busy", int'(bus.busy), 0);
        tick();
        chk("t0_done_single", int'(bus.done), 0);
        chk("t0_bank_unchanged", int'(bus.bank_sel), run_bank);

        // Back-pressure on COLLIDE cycles 3..5: issue stalls, address held.
        launch(1);
        for (int c = 1; c <= 5; c++) begin
            ready_val = (c >= 3) ? 1'b0 : 1'b1;
            tick();
            if (c >= 3) begin
                #1;
                chk("bubble_rd_valid", int'(bus.rd_valid), 0);
                chk("bubble_rd_addr_held", int'(bus.rd_addr), 3);
            end
        end
        ready_val = 1'b1;
        wait_done(200);

        // Abort in STREAM of step 2 of a 3-step run.
        run_bank = bank_m;
        launch(3);
        n = 0;
        while (n < 300 && !(int'(bus.steps_done) == 1 && int'(bus.phase) == 2)) begin
            tick();
            n++;
        end
        chk("reached_stream_step2", int'(n < 300), 1);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        clear_model();
        bank_m = run_bank ^ 1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_phase", int'(bus.phase), 0);
        chk("abort_steps_done", int'(bus.steps_done), 1);
        chk("abort_bank", int'(bus.bank_sel), bank_m);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_wr", int'(bus.wr_en), 0);
            chk("abort_no_done", int'(bus.done), 0);
        end
        // abort while idle together with start: nothing happens.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.step_target = 32'd2;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_beats_start", int'(bus.busy), 0);
        launch(1);
        wait_done(200);

        // Randomized back-pressure and step counts; start re-issued mid-run.
        rand_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            launch($urandom_range(1, 3));
            repeat (6) tick();
            bus.start = 1'b1;
            bus.step_target = 32'd9;
            tick();
            bus.start = 1'b0;
            wait_done(800);
        end

        // Asynchronous reset in the middle of COLLIDE issue.
        launch(2);
        repeat (5) tick();
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        clear_model();
        bank_m = 0;
        tick();
        tick();
        rst = 1'b1;
        rand_ready = 1'b0;
        launch(1);
        wait_done(200);

        chk("final_queues_empty", int'(exp_rd.size() + exp_wr.size() + exp_dn.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
